hex_keypad_entry: RTL and testbench
===================================

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each row is driven before its columns are sampled.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000, consecutive stable cycles needed to accept a press or a release.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port row  output  4  keypad row drive, active-low, one-cold.
REQ-006 SHALL have port col  input  4  keypad column sense, active-low, externally pulled up, asynchronous.
REQ-007 SHALL have port clear  input  1  synchronous clear of the entered value.
REQ-008 SHALL have port value  output  16  four most recent hex digits; newest in [3:0]; feeds the hex display data input.
REQ-009 SHALL have port key_code  output  4  code of the last accepted key.
REQ-010 SHALL have port key_valid  output  1  one-cycle pulse per accepted key.

Function
REQ-011 SHALL pass col through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-012 SHALL drive row = ~(4'b0001 << row_idx), where row_idx is a 2-bit index.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, HOLD.
REQ-014 SCAN: SHALL hold the row for SCAN_DIV cycles, then sample col_s. If col_s == 4'hF, row_idx increments with wrap 3->0 and the dwell restarts; otherwise capture col_s and go to DEBOUNCE with row held.
REQ-015 DEBOUNCE: SHALL count cycles where col_s equals the captured pattern. On any mismatch, return to SCAN at the same row with the counter cleared. When the count reaches DEBOUNCE_CNT, accept the key and go to HOLD.
REQ-016 Key code SHALL be {row_idx, col_idx}, where col_idx is the lowest-index low column; multiple low columns resolve to the lowest.
REQ-017 On accept, in the same cycle: key_valid=1, key_code=code, value <= {value[11:0], code}; the oldest digit is discarded.
REQ-018 HOLD: SHALL keep the row driven until col_s == 4'hF for DEBOUNCE_CNT consecutive cycles, then return to SCAN at row_idx+1. A new press during HOLD SHALL produce no key_valid.
REQ-019 clear SHALL set value to 0 in the next cycle, in any state. If clear coincides with an accept, clear wins for value, but key_valid and key_code still update.
REQ-020 Latency from a stable press on the sampled row to key_valid SHALL be exactly DEBOUNCE_CNT+1 cycles after the sampling cycle.

Reset
REQ-021 While reset=1, SHALL force: state=SCAN, row_idx=0, row=4'b1110, value=16'h0000, key_code=4'h0, key_valid=0, counters=0, synchronizer flops=4'hF.
REQ-022 Reset mid-DEBOUNCE or mid-HOLD SHALL abandon the key with no key_valid; a key still held after reset is re-detected through the normal SCAN path.

Configuration
REQ-023 Macro HEX_KEYPAD_DEBOUNCE_EN: when defined, behaviour is per REQ-015/REQ-018.
REQ-024 When HEX_KEYPAD_DEBOUNCE_EN is undefined, SHALL treat DEBOUNCE_CNT as 1: accept on the cycle after detection, and release after one all-high cycle (simulation speed and bench use).

Structure
REQ-025 Shared package hex_pkg SHALL hold the FSM state typedef, the constant NUM_ROWS=4, and the idle column constant COL_IDLE=4'hF.
REQ-026 SHALL instantiate one sub-module, key_stable_counter: a compare/count/done block reused by DEBOUNCE and HOLD.

Verification (bench: SCAN_DIV=4, DEBOUNCE_CNT=8, macro defined)
REQ-027 Press row2/col1 held for 50 cycles -> one key_valid, key_code=4'h9, value=16'h0009.
REQ-028 Press sequence codes 1,2,3,4,5, each released 20 cycles -> value=16'h2345, five key_valid pulses.
REQ-029 Bounce: col toggles every 3 cycles for 30 cycles, then stays stable -> exactly one key_valid, only after stable plus 9 cycles.
REQ-030 Row3 with col0 and col2 low together -> key_code=4'hC; key held 200 cycles -> still a single pulse.
REQ-031 clear asserted in the same cycle as an accept of code 7 with value=16'h1234 -> value=0, key_valid=1, key_code=7.
REQ-032 Reset asserted mid-DEBOUNCE -> outputs at reset values, no key_valid; after reset release with the key still held -> key accepted once.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and constants for the hex keypad entry block.
package hex_pkg;

  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned ROW_IDX_W = 2;
  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } kp_state_e;

  // Index of the lowest-numbered low (active) column; 0 when none is low.
  function automatic logic [1:0] low_col_idx(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_stable_counter.sv
// Counts consecutive cycles in which match_i holds while enabled and
// flags the cycle in which the run reaches TARGET. The run restarts
// after a hit, on any mismatch, and whenever the block is disabled.
module key_stable_counter #(
  parameter int unsigned TARGET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic match_i,
  output logic done_c
);

  localparam int unsigned CW = (TARGET > 1) ? $clog2(TARGET) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  // Hit detection and next run length.
  always_comb begin
    at_last = (cnt_q == CW'(TARGET - 1));
    done_c  = en_i && match_i && at_last;
    cnt_d   = cnt_q;
    if (!en_i || !match_i || at_last) cnt_d = '0;
    else                              cnt_d = cnt_q + CW'(1);
  end

  // Run-length register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce and a four-digit entry shift register.
// HEX_KEYPAD_DEBOUNCE_EN: when defined, presses and releases must be stable
// for DEBOUNCE_CNT cycles; when undefined a single cycle is enough.
module hex_keypad_entry
  import hex_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_ROWS-1:0] row,
  input  logic [NUM_COLS-1:0] col,
  input  logic                clear,
  output logic [15:0]         value,
  output logic [3:0]          key_code,
  output logic                key_valid
);

`ifdef HEX_KEYPAD_DEBOUNCE_EN
  localparam int unsigned DB_EFF = DEBOUNCE_CNT;
`else
  localparam int unsigned DB_EFF = (DEBOUNCE_CNT > 0) ? 1 : 1;
`endif
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_COLS-1:0]  col_meta_q, col_sync_q;
  kp_state_e            state_q;
  logic [ROW_IDX_W-1:0] row_idx_q;
  logic [NUM_ROWS-1:0]  row_q;
  logic [DIV_W-1:0]     div_q;
  logic [NUM_COLS-1:0]  pat_q;
  logic [15:0]          value_q;
  logic [3:0]           key_code_q;
  logic                 key_valid_q;

  logic                 stable_en_c;
  logic                 stable_match_c;
  logic                 stable_done_c;
  logic                 accept_c;
  logic [3:0]           code_c;
  logic                 dwell_end_c;

  assign row       = row_q;
  assign value     = value_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_q <= COL_IDLE;
      col_sync_q <= COL_IDLE;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Stability target: captured press pattern while debouncing, idle while holding.
  always_comb begin
    stable_en_c    = (state_q != SCAN);
    stable_match_c = (state_q == DEBOUNCE) ? (col_sync_q == pat_q)
                                           : (col_sync_q == COL_IDLE);
    accept_c       = (state_q == DEBOUNCE) && stable_done_c;
    code_c         = {row_idx_q, low_col_idx(pat_q)};
    dwell_end_c    = (div_q == DIV_W'(SCAN_DIV - 1));
  end

  key_stable_counter #(
    .TARGET (DB_EFF)
  ) u_stable (
    .clk     (clk),
    .reset   (reset),
    .en_i    (stable_en_c),
    .match_i (stable_match_c),
    .done_c  (stable_done_c)
  );

  // Scan / debounce / hold sequencing with registered row drive and key outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_idx_q   <= '0;
      row_q       <= 4'b1110;
      div_q       <= '0;
      pat_q       <= COL_IDLE;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (dwell_end_c) begin
            div_q <= '0;
            if (col_sync_q == COL_IDLE) begin
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= {row_q[NUM_ROWS-2:0], row_q[NUM_ROWS-1]};
            end else begin
              pat_q   <= col_sync_q;
              state_q <= DEBOUNCE;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DEBOUNCE: begin
          if (col_sync_q != pat_q) begin
            state_q <= SCAN;
          end else if (accept_c) begin
            key_valid_q <= 1'b1;
            key_code_q  <= code_c;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (stable_done_c) begin
            state_q   <= SCAN;
            row_idx_q <= row_idx_q + 2'd1;
            row_q     <= {row_q[NUM_ROWS-2:0], row_q[NUM_ROWS-1]};
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  // Entered digits: clear has priority over a coincident accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         value_q <= 16'h0000;
    else if (clear)    value_q <= 16'h0000;
    else if (accept_c) value_q <= {value_q[11:0], code_c};
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural 4x4 keypad.
module tb_hex_keypad_entry;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 8;
`ifdef HEX_KEYPAD_DEBOUNCE_EN
  localparam int EFF_DB = 8;
`else
  localparam int EFF_DB = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;

  logic        key_on;
  logic [1:0]  key_row;
  logic [3:0]  key_mask;

  int n_checks   = 0;
  int n_fail     = 0;
  int kv_count   = 0;
  int exp_pulses = 0;
  int cyc        = 0;

  typedef struct {
    logic        clr_first;
    logic [1:0]  r;
    logic [3:0]  m;
    logic [3:0]  code;
    logic [15:0] val;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  hex_keypad_entry #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .clear     (clear),
    .value     (value),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: pressed columns read low only while their row is driven low.
  always_comb col = (key_on && (row[key_row] == 1'b0)) ? ~key_mask : 4'hF;

  always @(negedge clk) if (key_valid) kv_count = kv_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait at negedges until (row drives r) equals want; bounded.
  task automatic wait_row(input logic [1:0] r, input bit want, input string name);
    logic [3:0] one;
    logic [3:0] pat;
    int k;
    one = 4'b0001 << r;
    pat = ~one;
    k   = 0;
    while (((row == pat) != want) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting on row %b", name, pat);
    end
  endtask

  // Press a key before its row comes up, check exact latency, hold, release.
  task automatic do_key(input logic [1:0] r, input logic [3:0] m, input logic [3:0] code,
                        input logic [15:0] exp_val, input int hold, input string name);
    wait_row(r, 1'b0, {name, "_leave"});
    key_row  = r;
    key_mask = m;
    key_on   = 1'b1;
    wait_row(r, 1'b1, {name, "_arrive"});
    repeat (SCAN_DIV + EFF_DB - 1) @(negedge clk);
    check({name, "_early"}, 32'(key_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(key_valid), 32'd1);
    check({name, "_code"}, 32'(key_code), 32'(code));
    check({name, "_value"}, 32'(value), 32'(exp_val));
    exp_pulses++;
    @(negedge clk);
    check({name, "_pulse_width"}, 32'(key_valid), 32'd0);
    repeat (hold) @(negedge clk);
    key_on = 1'b0;
    repeat (20) @(negedge clk);
    check({name, "_pulses"}, 32'(kv_count), 32'(exp_pulses));
  endtask

  initial begin
    int k;
    int start;
    reset    = 1'b1;
    clear    = 1'b0;
    key_on   = 1'b0;
    key_row  = 2'd0;
    key_mask = 4'h0;

    vecs[0]  = '{1'b0, 2'd2, 4'b0010, 4'h9, 16'h0009, 50};
    vecs[1]  = '{1'b0, 2'd0, 4'b0010, 4'h1, 16'h0091, 30};
    vecs[2]  = '{1'b0, 2'd0, 4'b0100, 4'h2, 16'h0912, 30};
    vecs[3]  = '{1'b0, 2'd0, 4'b1000, 4'h3, 16'h9123, 30};
    vecs[4]  = '{1'b0, 2'd1, 4'b0001, 4'h4, 16'h1234, 30};
    vecs[5]  = '{1'b0, 2'd1, 4'b0010, 4'h5, 16'h2345, 30};
    vecs[6]  = '{1'b0, 2'd3, 4'b0101, 4'hC, 16'h345C, 200};
    vecs[7]  = '{1'b1, 2'd0, 4'b0010, 4'h1, 16'h0001, 10};
    vecs[8]  = '{1'b0, 2'd0, 4'b0100, 4'h2, 16'h0012, 10};
    vecs[9]  = '{1'b0, 2'd0, 4'b1000, 4'h3, 16'h0123, 10};
    vecs[10] = '{1'b0, 2'd1, 4'b0001, 4'h4, 16'h1234, 10};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_row", 32'(row), 32'hE);
    check("rst_value", 32'(value), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven presses.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].clr_first) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check($sformatf("v%0d_clear", i), 32'(value), 32'h0);
      end
      do_key(vecs[i].r, vecs[i].m, vecs[i].code, vecs[i].val, vecs[i].hold,
             $sformatf("v%0d", i));
    end

    // Clear coinciding with the accept of code 7 while value is 1234.
    wait_row(2'd1, 1'b0, "clr_leave");
    key_row  = 2'd1;
    key_mask = 4'b1000;
    key_on   = 1'b1;
    wait_row(2'd1, 1'b1, "clr_arrive");
    repeat (SCAN_DIV + EFF_DB - 1) @(negedge clk);
    check("clr_before_value", 32'(value), 32'h1234);
    check("clr_before_valid", 32'(key_valid), 32'h0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_valid", 32'(key_valid), 32'h1);
    check("clr_code", 32'(key_code), 32'h7);
    check("clr_value", 32'(value), 32'h0);
    exp_pulses++;
    repeat (10) @(negedge clk);
    key_on = 1'b0;
    repeat (20) @(negedge clk);
    check("clr_pulses", 32'(kv_count), 32'(exp_pulses));

    do_key(2'd1, 4'b1000, 4'h7, 16'h0007, 10, "k7");

`ifdef HEX_KEYPAD_DEBOUNCE_EN
    // Contact bounce: 3-cycle toggles must never be accepted.
    key_row  = 2'd2;
    key_mask = 4'b0010;
    for (int p = 0; p < 10; p++) begin
      key_on = (p % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_nopulse", 32'(kv_count), 32'(exp_pulses));
    key_on = 1'b1;
    start  = cyc;
    k      = 0;
    while (!key_valid && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    check("bounce_seen", 32'(key_valid), 32'h1);
    check("bounce_lat_min", 32'(((cyc - start) >= (EFF_DB + 1)) ? 1 : 0), 32'h1);
    check("bounce_code", 32'(key_code), 32'h9);
    check("bounce_value", 32'(value), 32'h0079);
    exp_pulses++;
    repeat (20) @(negedge clk);
    key_on = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_pulses", 32'(kv_count), 32'(exp_pulses));
`endif

    // Reset in the middle of debouncing, then re-detection of the held key.
    wait_row(2'd2, 1'b0, "rd_leave");
    key_row  = 2'd2;
    key_mask = 4'b0010;
    key_on   = 1'b1;
    wait_row(2'd2, 1'b1, "rd_arrive");
    repeat (SCAN_DIV) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rd_row", 32'(row), 32'hE);
    check("rd_value", 32'(value), 32'h0);
    check("rd_code", 32'(key_code), 32'h0);
    check("rd_valid", 32'(key_valid), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rd_nopulse", 32'(kv_count), 32'(exp_pulses));
    k = 0;
    while (!key_valid && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    check("rd_redetect", 32'(key_valid), 32'h1);
    check("rd_redetect_code", 32'(key_code), 32'h9);
    check("rd_redetect_value", 32'(value), 32'h0009);
    exp_pulses++;
    repeat (30) @(negedge clk);
    key_on = 1'b0;
    repeat (20) @(negedge clk);
    check("rd_pulses", 32'(kv_count), 32'(exp_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
